// File: rtl/lut_pkg.sv
// Shared LUT geometry constants and loader FSM state encoding.
// Pure definitions: no logic, no latency, no flow control.
package lut_pkg;

  localparam int PLANES          = 3;
  localparam int DIM             = 50;
  localparam int UPSCALE         = 4;
  localparam int DW              = 8;
  localparam int ENTRIES         = PLANES * DIM * DIM;
  localparam int BEATS_PER_ENTRY = 4;
  localparam int ADDR_W          = 13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/lut_idx_counter.sv
// b/a/plane entry counter with linear address and final-entry flag.
// Advances one entry per adv_i pulse, zero latency on outputs; no backpressure.
module lut_idx_counter
  import lut_pkg::ADDR_W;
#(
  parameter int PLANES = lut_pkg::PLANES,
  parameter int DIM    = lut_pkg::DIM
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              adv_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  localparam int BW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int PW = (PLANES > 1) ? $clog2(PLANES) : 1;

  logic [BW-1:0]     b_q, b_d, a_q, a_d;
  logic [PW-1:0]     p_q, p_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              b_wrap, a_wrap;

  assign b_wrap = (b_q == BW'(DIM - 1));
  assign a_wrap = (a_q == BW'(DIM - 1));
  assign last_o = b_wrap && a_wrap && (p_q == PW'(PLANES - 1));
  assign addr_o = addr_q;

  // The linear address runs alongside the axis counters since b is innermost.
  always_comb begin
    b_d    = b_q;
    a_d    = a_q;
    p_d    = p_q;
    addr_d = addr_q;
    if (clr_i) begin
      b_d    = '0;
      a_d    = '0;
      p_d    = '0;
      addr_d = '0;
    end else if (adv_i) begin
      addr_d = last_o ? '0 : addr_q + ADDR_W'(1);
      if (b_wrap) begin
        b_d = '0;
        if (a_wrap) begin
          a_d = '0;
          p_d = last_o ? '0 : p_q + PW'(1);
        end else begin
          a_d = a_q + BW'(1);
        end
      end else begin
        b_d = b_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      b_q    <= '0;
      a_q    <= '0;
      p_q    <= '0;
      addr_q <= '0;
    end else begin
      b_q    <= b_d;
      a_q    <= a_d;
      p_q    <= p_d;
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/lut_loader.sv
// Packs 32-bit beats into LUT entries and writes them in order; LUT_LOADER_CKSUM_EN adds a byte checksum.
// Write one cycle after each 4th beat, no stalls; s_ready high only while loading.
module lut_loader
  import lut_pkg::state_t, lut_pkg::IDLE, lut_pkg::LOAD, lut_pkg::FLUSH, lut_pkg::DONE,
         lut_pkg::ADDR_W, lut_pkg::BEATS_PER_ENTRY;
#(
  parameter int PLANES  = lut_pkg::PLANES,
  parameter int DIM     = lut_pkg::DIM,
  parameter int UPSCALE = lut_pkg::UPSCALE,
  parameter int DW      = lut_pkg::DW
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [31:0]                   s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          wr_en,
  output logic [ADDR_W-1:0]             wr_addr,
  output logic [UPSCALE*UPSCALE*DW-1:0] wr_data,
  output logic                          busy,
  output logic                          done
`ifdef LUT_LOADER_CKSUM_EN
  ,
  input  logic [15:0]                   cksum_exp,
  output logic                          cksum_err
`endif
);

  localparam int EW = UPSCALE * UPSCALE * DW;

  state_t            state_q, state_d;
  logic [1:0]        beat_q, beat_d;
  logic [EW-33:0]    buf_q, buf_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [EW-1:0]     wr_data_q, wr_data_d;
  logic              hs, last_beat, entry_done, cnt_clr, idx_last;
  logic [ADDR_W-1:0] idx_addr;

  assign s_ready    = (state_q == LOAD);
  assign busy       = (state_q == LOAD) || (state_q == FLUSH);
  assign done       = (state_q == DONE);
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;

  // Abort wins over a beat presented in the same cycle.
  assign hs         = s_valid && s_ready && !abort;
  assign last_beat  = (beat_q == 2'(BEATS_PER_ENTRY - 1));
  assign entry_done = hs && last_beat;
  assign cnt_clr    = (state_q == IDLE) && start && !abort;

  lut_idx_counter #(
    .PLANES (PLANES),
    .DIM    (DIM)
  ) u_idx (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clr_i  (cnt_clr),
    .adv_i  (entry_done),
    .addr_o (idx_addr),
    .last_o (idx_last)
  );

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    buf_d     = buf_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = LOAD;
            beat_d  = '0;
          end
        end
        LOAD: begin
          if (hs) begin
            beat_d = beat_q + 2'd1;
            if (last_beat) begin
              wr_en_d   = 1'b1;
              wr_addr_d = idx_addr;
              wr_data_d = {s_data, buf_q};
              if (idx_last) state_d = FLUSH;
            end else begin
              // Shifting down leaves beat k at bits 32k once the entry is full.
              buf_d = {s_data, buf_q[EW-33:32]};
            end
          end
        end
        FLUSH:   state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      buf_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      buf_q     <= buf_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

`ifdef LUT_LOADER_CKSUM_EN
  logic [15:0] cksum_q, cksum_d;
  logic        cksum_err_q, cksum_err_d;

  always_comb begin
    cksum_d     = cksum_q;
    cksum_err_d = cksum_err_q;
    if (cnt_clr) begin
      cksum_d     = '0;
      cksum_err_d = 1'b0;
    end else begin
      if (hs) begin
        cksum_d = cksum_q + {8'd0, s_data[7:0]} + {8'd0, s_data[15:8]}
                          + {8'd0, s_data[23:16]} + {8'd0, s_data[31:24]};
      end
      if (state_q == FLUSH && !abort) cksum_err_d = (cksum_q != cksum_exp);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cksum_q     <= '0;
      cksum_err_q <= 1'b0;
    end else begin
      cksum_q     <= cksum_d;
      cksum_err_q <= cksum_err_d;
    end
  end

  assign cksum_err = cksum_err_q;
`endif

endmodule

// File: tb/tb_lut_loader.sv
// Randomized bench for lut_loader against a queue-based entry model.
`timescale 1ns/1ps
module tb_lut_loader;

  localparam int N_ENTRIES = 7500;
  localparam int N_BEATS   = 4 * N_ENTRIES;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [31:0]  s_data = '0;
  logic         s_valid = 1'b0;
  logic         s_ready, wr_en, busy, done;
  logic [12:0]  wr_addr;
  logic [127:0] wr_data;
`ifdef LUT_LOADER_CKSUM_EN
  logic [15:0]  cksum_exp = '0;
  logic         cksum_err;
`endif

  int vectors = 0;
  int errors  = 0;
  int done_cnt = 0;

  logic [12:0]  obs_addr[$];
  logic [127:0] obs_data[$];

  // Reference model: completed entries in address order plus byte sum.
  logic [127:0] exp_data[$];
  logic [127:0] cur_entry;
  int           cur_beats;
  logic [15:0]  model_sum;

  always #5 clk = ~clk;

  lut_loader dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy),
    .done    (done)
`ifdef LUT_LOADER_CKSUM_EN
    ,
    .cksum_exp (cksum_exp),
    .cksum_err (cksum_err)
`endif
  );

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      obs_addr.push_back(wr_addr);
      obs_data.push_back(wr_data);
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic model_reset();
    exp_data.delete();
    cur_beats = 0;
    cur_entry = '0;
    model_sum = '0;
  endtask

  task automatic model_beat(input logic [31:0] d);
    cur_entry[32*cur_beats +: 32] = d;
    cur_beats++;
    model_sum = model_sum + 16'(d[7:0]) + 16'(d[15:8]) + 16'(d[23:16]) + 16'(d[31:24]);
    if (cur_beats == 4) begin
      exp_data.push_back(cur_entry);
      cur_beats = 0;
    end
  endtask

  task automatic clear_obs();
    obs_addr.delete();
    obs_data.delete();
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Presents one beat until accepted; rnd inserts random idle cycles first.
  task automatic send_beat(input logic [31:0] d, input bit rnd);
    int waited = 0;
    bit taken = 1'b0;
    if (rnd) begin
      while ($urandom_range(1, 0) == 0) begin
        s_valid = 1'b0;
        s_data  = $urandom;
        @(posedge clk); #1;
      end
    end
    s_valid = 1'b1;
    s_data  = d;
    while (!taken) begin
      taken = (s_ready === 1'b1);
      @(posedge clk); #1;
      if (!taken) begin
        waited++;
        if (waited > 100) begin
          vectors++;
          errors++;
          $display("FAIL handshake_timeout: s_ready=%b after %0d cycles, want 1", s_ready, waited);
          $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
          $fatal(1, "handshake timeout");
        end
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({s_ready, wr_en, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got {s_ready,wr_en,busy,done}=%b want 0000", {s_ready, wr_en, busy, done});
    end
    vectors++;
    if (wr_addr !== 13'd0) begin
      errors++;
      $display("FAIL reset_wr_addr: got %0d want 0", wr_addr);
    end
    vectors++;
    if (wr_data !== 128'd0) begin
      errors++;
      $display("FAIL reset_wr_data: got %h want 0", wr_data);
    end
`ifdef LUT_LOADER_CKSUM_EN
    vectors++;
    if (cksum_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_cksum_err: got %b want 0", cksum_err);
    end
`endif
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (s_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_start: got s_ready=%b busy=%b want 0 0", s_ready, busy);
    end
  endtask

  task automatic test_single_entry();
    logic [31:0] beats[4] = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
    int dc0 = done_cnt;
    model_reset();
    do_start();
    vectors++;
    if (s_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_load: got s_ready=%b busy=%b want 1 1", s_ready, busy);
    end
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (wr_en !== 1'b0) begin
        errors++;
        $display("FAIL early_wr_en: beat %0d got %b want 0", k, wr_en);
      end
      send_beat(beats[k], 1'b0);
      model_beat(beats[k]);
    end
    vectors++;
    if (wr_en !== 1'b1 || wr_addr !== 13'd0) begin
      errors++;
      $display("FAIL single_write: got wr_en=%b wr_addr=%0d want 1 0", wr_en, wr_addr);
    end
    vectors++;
    if (wr_data !== 128'h0F0E0D0C_0B0A0908_07060504_03020100) begin
      errors++;
      $display("FAIL single_data: got %h want 0f0e0d0c0b0a090807060504030201 00", wr_data);
    end
    @(posedge clk); #1;
    vectors++;
    if (wr_en !== 1'b0) begin
      errors++;
      $display("FAIL single_wr_drop: got %b want 0", wr_en);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    vectors++;
    if (busy !== 1'b0 || done_cnt != dc0) begin
      errors++;
      $display("FAIL single_abort: got busy=%b done_pulses=%0d want 0 0", busy, done_cnt - dc0);
    end
  endtask

  task automatic test_full_load();
    logic [31:0] d;
    int dc0 = done_cnt;
    int n;
    clear_obs();
    model_reset();
`ifdef LUT_LOADER_CKSUM_EN
    cksum_exp = 16'h0000;
`endif
    do_start();
    for (int i = 0; i < N_BEATS; i++) begin
      if (i == N_BEATS / 2) begin
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
      d = $urandom;
      send_beat(d, 1'b1);
      model_beat(d);
    end
    // Overrun beat held valid from the final handshake onward.
    s_valid = 1'b1;
    s_data  = $urandom;
    vectors++;
    if (s_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_state: got s_ready=%b busy=%b want 0 1", s_ready, busy);
    end
    vectors++;
    if (wr_en !== 1'b1 || wr_addr !== 13'd7499) begin
      errors++;
      $display("FAIL final_write: got wr_en=%b wr_addr=%0d want 1 7499", wr_en, wr_addr);
    end
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || wr_en !== 1'b0 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL done_cycle: got done=%b busy=%b wr_en=%b s_ready=%b want 1 0 0 0", done, busy, wr_en, s_ready);
    end
`ifdef LUT_LOADER_CKSUM_EN
    vectors++;
    if (cksum_err !== (model_sum != 16'h0000)) begin
      errors++;
      $display("FAIL cksum_mismatch: got %b want %b (sum %h)", cksum_err, model_sum != 16'h0000, model_sum);
    end
`endif
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      vectors++;
      if (s_ready !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL overrun_idle: cycle %0d got s_ready=%b done=%b want 0 0", c, s_ready, done);
      end
    end
    s_valid = 1'b0;
`ifdef LUT_LOADER_CKSUM_EN
    vectors++;
    if (cksum_err !== (model_sum != 16'h0000)) begin
      errors++;
      $display("FAIL cksum_hold: got %b want %b", cksum_err, model_sum != 16'h0000);
    end
`endif
    vectors++;
    if (obs_addr.size() != N_ENTRIES || done_cnt - dc0 != 1) begin
      errors++;
      $display("FAIL full_counts: got writes=%0d done_pulses=%0d want 7500 1", obs_addr.size(), done_cnt - dc0);
    end
    n = (obs_addr.size() < exp_data.size()) ? obs_addr.size() : exp_data.size();
    for (int i = 0; i < n; i++) begin
      vectors++;
      if (obs_addr[i] !== 13'(i) || obs_data[i] !== exp_data[i]) begin
        errors++;
        $display("FAIL full_entry %0d: got addr=%0d data=%h want addr=%0d data=%h",
                 i, obs_addr[i], obs_data[i], i, exp_data[i]);
      end
    end
  endtask

  task automatic test_abort();
    logic [31:0] d;
    int dc0 = done_cnt;
    clear_obs();
    model_reset();
    do_start();
    for (int i = 0; i < 42; i++) begin
      d = $urandom;
      send_beat(d, 1'b1);
    end
    abort   = 1'b1;
    s_valid = 1'b1;
    s_data  = $urandom;
    @(posedge clk); #1;
    abort   = 1'b0;
    s_valid = 1'b0;
    vectors++;
    if (s_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: got s_ready=%b busy=%b want 0 0", s_ready, busy);
    end
    repeat (5) @(posedge clk);
    #1;
    vectors++;
    if (obs_addr.size() != 10 || done_cnt != dc0) begin
      errors++;
      $display("FAIL abort_writes: got writes=%0d done_pulses=%0d want 10 0", obs_addr.size(), done_cnt - dc0);
    end else begin
      vectors++;
      if (obs_addr[9] !== 13'd9) begin
        errors++;
        $display("FAIL abort_last_addr: got %0d want 9", obs_addr[9]);
      end
    end
    // Restart must begin again at entry 0.
    clear_obs();
    model_reset();
    do_start();
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      send_beat(d, 1'b1);
      model_beat(d);
    end
    vectors++;
    if (wr_en !== 1'b1 || wr_addr !== 13'd0 || wr_data !== exp_data[0]) begin
      errors++;
      $display("FAIL restart_write: got wr_en=%b addr=%0d data=%h want 1 0 %h", wr_en, wr_addr, wr_data, exp_data[0]);
    end
    for (int i = 0; i < 3; i++) send_beat($urandom, 1'b0);
    abort   = 1'b1;
    s_valid = 1'b1;
    s_data  = $urandom;
    @(posedge clk); #1;
    abort   = 1'b0;
    s_valid = 1'b0;
    vectors++;
    if (wr_en !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_priority: got wr_en=%b busy=%b want 0 0", wr_en, busy);
    end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (obs_addr.size() != 1) begin
      errors++;
      $display("FAIL abort_priority_writes: got %0d want 1", obs_addr.size());
    end
  endtask

  task automatic test_reset_midload();
    clear_obs();
    do_start();
    for (int i = 0; i < 402; i++) send_beat($urandom, 1'b0);
    s_valid = 1'b1;
    s_data  = $urandom;
    #3 rst_n = 1'b0;
    #1;
    vectors++;
    if ({s_ready, wr_en, busy, done} !== 4'b0000 || wr_addr !== 13'd0 || wr_data !== 128'd0) begin
      errors++;
      $display("FAIL async_reset: got ctrl=%b addr=%0d data=%h want 0000 0 0",
               {s_ready, wr_en, busy, done}, wr_addr, wr_data);
    end
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    s_valid = 1'b0;
    vectors++;
    if (obs_addr.size() != 100 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_write: got writes=%0d busy=%b want 100 0", obs_addr.size(), busy);
    end else begin
      vectors++;
      if (obs_addr[99] !== 13'd99) begin
        errors++;
        $display("FAIL reset_last_addr: got %0d want 99", obs_addr[99]);
      end
    end
  endtask

`ifdef LUT_LOADER_CKSUM_EN
  task automatic test_cksum();
    cksum_exp = 16'hD4C0;
    do_start();
    for (int i = 0; i < N_BEATS; i++) send_beat(32'h01010101, 1'b0);
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b1 || cksum_err !== 1'b0) begin
      errors++;
      $display("FAIL cksum_match: got done=%b cksum_err=%b want 1 0", done, cksum_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_entry();
    test_full_load();
    test_abort();
    test_reset_midload();
`ifdef LUT_LOADER_CKSUM_EN
    test_cksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/lut_loader.md
LUT_LOADER -- requirements
Module: lut_loader

Interface
REQ-001 SHALL have parameter PLANES, default 3, the number of LUT planes.
REQ-002 SHALL have parameter DIM, default 50, the samples per LUT axis.
REQ-003 SHALL have parameter UPSCALE, default 4, the upscale factor; an entry holds UPSCALE*UPSCALE values.
REQ-004 SHALL have parameter DW, default 8, the width of one signed LUT value.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port start, input, 1 bit: a one-cycle request to begin a load.
REQ-008 SHALL have port abort, input, 1 bit: cancels a load in progress.
REQ-009 SHALL have port s_data, input, 32 bits: four LUT bytes per beat.
REQ-010 SHALL have port s_valid, input, 1 bit: source beat valid.
REQ-011 SHALL have port s_ready, output, 1 bit: loader accepts a beat.
REQ-012 SHALL have port wr_en, output, 1 bit: LUT memory write strobe.
REQ-013 SHALL have port wr_addr, output, 13 bits: entry index, plane*DIM*DIM + a*DIM + b.
REQ-014 SHALL have port wr_data, output, 128 bits: one packed entry.
REQ-015 SHALL have ports busy and done, outputs, 1 bit each: load active; one-cycle completion pulse.

Function
REQ-016 SHALL use FSM states IDLE, LOAD, FLUSH and DONE.
REQ-017 SHALL move IDLE->LOAD on start, clearing the beat counter, the b/a/plane counters and the checksum.
REQ-018 SHALL hold s_ready=1 only in LOAD; a handshake is s_valid&&s_ready.
REQ-019 SHALL place byte j of beat k (bits 8j+7:8j) at wr_data[32k+8j+7:32k+8j], for k=0..3.
REQ-020 SHALL register wr_en=1 one cycle after the 4th beat of an entry, with wr_addr and wr_data stable in that cycle; there SHALL be no throughput stall.
REQ-021 SHALL advance counters b-innermost, then a, then plane, with b wrapping DIM-1->0 and carrying into a, and a wrapping and carrying into plane.
REQ-022 SHALL move LOAD->FLUSH on the 4th beat of entry PLANES*DIM*DIM-1 (7499), drop s_ready in the same cycle, issue that final write in FLUSH, then go to DONE.
REQ-023 SHALL pulse done for one cycle in DONE, then return to IDLE.
REQ-024 SHALL hold busy=1 in LOAD and FLUSH.
REQ-025 SHALL ignore start while busy.
REQ-026 SHALL, on abort in any state, go to IDLE on the next edge with no done pulse and discard any partial entry; a write already registered SHALL still complete; abort SHALL take priority over a simultaneous handshake.
REQ-027 SHALL keep wr_en=0 outside those write cycles.

Reset
REQ-028 SHALL, on rst_n low, immediately force state IDLE, all counters 0, and s_ready, wr_en, busy and done to 0; wr_addr, wr_data and cksum_err SHALL also be 0.
REQ-029 SHALL issue no write after a reset asserted mid-load.

Configuration
REQ-030 SHALL, when macro LUT_LOADER_CKSUM_EN is defined, add input cksum_exp[15:0] and output cksum_err; it SHALL accumulate the mod-2^16 unsigned sum of every accepted byte and set cksum_err in the done cycle if the sum differs from cksum_exp, holding the value until the next start.
REQ-031 SHALL, without LUT_LOADER_CKSUM_EN, omit those ports and the accumulator entirely.

Structure
REQ-032 SHALL place in a shared package lut_pkg: the constants PLANES, DIM, UPSCALE, DW, ENTRIES=PLANES*DIM*DIM, BEATS_PER_ENTRY=4 and ADDR_W=13, plus the FSM state enum.
REQ-033 SHALL implement the b/a/plane wrap-carry logic in one sub-module, lut_idx_counter, whose outputs are the linear address and a last flag.

Verification
REQ-034 SHALL test a single entry: start, then beats 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C -> wr_en one cycle after the last beat, wr_addr=0, wr_data=0x0F0E..0100.
REQ-035 SHALL test a full load: 30000 beats with s_valid random at 50% -> 7500 writes, addresses 0..7499 in order, wr_addr=50 follows 49, then a done pulse and busy=0.
REQ-036 SHALL test overrun: a 30001st beat presented -> s_ready=0 from the 30000th handshake onward and no write 7501.
REQ-037 SHALL test abort after 2 beats of entry 10 -> no write at address 10, no done, s_ready=0 next cycle; a new start then restarts at address 0.
REQ-038 SHALL test reset asserted mid-load at entry 100 -> all outputs 0 asynchronously and no further wr_en.
REQ-039 SHALL, with LUT_LOADER_CKSUM_EN, test all bytes 0x01 with cksum_exp=0x D4C0 (120000 mod 65536) -> cksum_err=0; with cksum_exp=0x0000 -> cksum_err=1.
